// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan
// Brief    : 4x4 matrix keypad scanner with whole-sweep debouncing, hex key
//            code output, one-cycle accept strobe, sticky ready flag and a
//            16-bit shift register of the last four accepted digits.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scan #(
    parameter logic [15:0] SCAN_DIV     = 16'd50000,
    parameter int          DEBOUNCE_CNT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    input  logic        key_ack,
    input  logic        num_clr,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_ready,
    output logic        key_down,
    output logic [15:0] num
);

    localparam logic [3:0] DB_LIMIT = 4'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HELD     = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    logic [3:0]  row_meta_q;
    logic [3:0]  row_sync_q;
    logic [15:0] div_cnt_q;
    logic [3:0]  col_sel_q;
    logic [15:0] map_q;

    logic        tick;
    logic        sweep_end;
    logic [1:0]  col_idx;
    logic [15:0] map_full;
    logic [4:0]  hit_cnt;
    logic [3:0]  hit_code;
    logic        is_none;
    logic        is_single;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  cand_q, cand_d;
    logic        accept;

    logic [3:0]  key_code_q;
    logic        key_valid_q;
    logic        key_ready_q;
    logic [15:0] num_q;

    assign tick      = (div_cnt_q == SCAN_DIV - 16'd1);
    assign sweep_end = tick && col_sel_q[3];

    // Two-flop synchronizer for the asynchronous, active-low row inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_q <= 4'b1111;
            row_sync_q <= 4'b1111;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
        end
    end

    // Binary index of the column currently being driven
    always_comb begin
        col_idx = 2'd0;
        unique case (col_sel_q)
            4'b0001: col_idx = 2'd0;
            4'b0010: col_idx = 2'd1;
            4'b0100: col_idx = 2'd2;
            default: col_idx = 2'd3;
        endcase
    end

    // Sweep map including the current column's sample, then classify it
    always_comb begin
        map_full = map_q;
        for (int r = 0; r < 4; r++) begin
            map_full[{2'(r), col_idx}] = ~row_sync_q[r];
        end
        hit_cnt  = 5'd0;
        hit_code = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (map_full[i]) begin
                hit_cnt  = hit_cnt + 5'd1;
                hit_code = 4'(i);
            end
        end
        is_none   = (hit_cnt == 5'd0);
        is_single = (hit_cnt == 5'd1);
    end

    // Column divider, column rotation and per-sweep map capture
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= 16'd0;
            col_sel_q <= 4'b0001;
            map_q     <= 16'd0;
        end else if (tick) begin
            div_cnt_q <= 16'd0;
            col_sel_q <= {col_sel_q[2:0], col_sel_q[3]};
            map_q     <= sweep_end ? 16'd0 : map_full;
        end else begin
            div_cnt_q <= div_cnt_q + 16'd1;
        end
    end

    // Debounce FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            cand_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
        end
    end

    // Debounce FSM next state; transitions happen only at sweep end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        accept  = 1'b0;
        if (sweep_end) begin
            case (state_q)
                S_IDLE: begin
                    if (is_single) begin
                        cand_d = hit_code;
                        if (DB_LIMIT == 4'd1) begin
                            accept  = 1'b1;
                            state_d = S_HELD;
                            cnt_d   = 4'd0;
                        end else begin
                            state_d = S_DEBOUNCE;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                S_DEBOUNCE: begin
                    if (is_single && (hit_code == cand_q)) begin
                        if (cnt_q + 4'd1 == DB_LIMIT) begin
                            accept  = 1'b1;
                            state_d = S_HELD;
                            cnt_d   = 4'd0;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = 4'd0;
                    end
                end
                S_HELD: begin
                    // No auto-repeat: any key activity simply keeps us here
                    if (is_none) begin
                        if (DB_LIMIT == 4'd1) begin
                            state_d = S_IDLE;
                            cnt_d   = 4'd0;
                        end else begin
                            state_d = S_RELEASE;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                default: begin
                    if (is_none) begin
                        if (cnt_q + 4'd1 == DB_LIMIT) begin
                            state_d = S_IDLE;
                            cnt_d   = 4'd0;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else begin
                        state_d = S_HELD;
                        cnt_d   = 4'd0;
                    end
                end
            endcase
        end
    end

    // Accept actions, ready flag handshake and digit shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_ready_q <= 1'b0;
            num_q       <= 16'd0;
        end else begin
            key_valid_q <= accept;
            if (accept) begin
                key_code_q <= cand_d;
            end
            // A new key outranks a simultaneous acknowledge
            if (accept) begin
                key_ready_q <= 1'b1;
            end else if (key_ack) begin
                key_ready_q <= 1'b0;
            end
            // A clear outranks a simultaneous shift-in
            if (num_clr) begin
                num_q <= 16'd0;
            end else if (accept) begin
                num_q <= {num_q[11:0], cand_d};
            end
        end
    end

    assign col       = ~col_sel_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_ready = key_ready_q;
    assign key_down  = (state_q == S_HELD) || (state_q == S_RELEASE);
    assign num       = num_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scan
// Brief    : Scoreboard bench for keypad_scan with a behavioural 4x4 keypad.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scan;

    localparam logic [15:0] SCAN_DIV     = 16'd4;
    localparam int          DEBOUNCE_CNT = 3;
    localparam int          SWEEP        = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        key_ack = 1'b0;
    logic        num_clr = 1'b0;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready;
    logic        key_down;
    logic [15:0] num;

    logic [15:0] keys = 16'd0;
    logic [15:0] model_num = 16'd0;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_bad = 0;

    typedef struct packed {
        logic [3:0]  code;
        logic [15:0] num;
        logic [31:0] at;
    } exp_t;

    exp_t exp_q[$];

    keypad_scan #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .key_ack   (key_ack),
        .num_clr   (num_clr),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_down  (key_down),
        .num       (num)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low while its column is driven low
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            row[r] = ~|(keys[4*r +: 4] & ~col);
        end
    end

    // Cycle index since the last reset edge
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic run_sweeps(input int n);
        repeat (n * SWEEP) @(negedge clk);
    endtask

    // Expect an accept three sweeps after the current sweep boundary
    task automatic push_exp(input logic [3:0] code, input logic clr);
        exp_t e;
        model_num = clr ? 16'd0 : {model_num[11:0], code};
        e.code = code;
        e.num  = model_num;
        e.at   = 32'(cyc + DEBOUNCE_CNT * SWEEP);
        exp_q.push_back(e);
    endtask

    task automatic press(input logic [3:0] code, input int hold, input int rel);
        push_exp(code, 1'b0);
        keys = 16'd1 << code;
        run_sweeps(hold);
        keys = 16'd0;
        run_sweeps(rel);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_col"},       32'(col),       32'hE);
        chk({tag, "_key_code"},  32'(key_code),  32'h0);
        chk({tag, "_key_valid"}, 32'(key_valid), 32'h0);
        chk({tag, "_key_ready"}, 32'(key_ready), 32'h0);
        chk({tag, "_key_down"},  32'(key_down),  32'h0);
        chk({tag, "_num"},       32'(num),       32'h0);
    endtask

    // Monitor: every key_valid pulse must match the oldest expected accept
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && key_valid) begin
                if (exp_q.size() == 0) begin
                    chk("stray_key_valid", 32'(key_valid), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("acc_code",  32'(key_code),  32'(e.code));
                    chk("acc_num",   32'(num),       32'(e.num));
                    chk("acc_ready", 32'(key_ready), 32'h1);
                    chk("acc_down",  32'(key_down),  32'h1);
                    chk("acc_cycle", 32'(cyc),       e.at);
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        logic [3:0] ecol;

        // 1: reset values and idle column rotation
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_values("reset");
        rst = 1'b0;
        for (int i = 0; i < SWEEP; i++) begin
            ecol = ~(4'b0001 << (i / 4));
            chk("col_scan", 32'(col), 32'(ecol));
            @(negedge clk);
        end
        chk("col_wrap", 32'(col), 32'hE);

        // 2: key 9 held six sweeps, then released
        push_exp(4'h9, 1'b0);
        keys = 16'd1 << 9;
        run_sweeps(6);
        chk("held_down",  32'(key_down),  32'h1);
        chk("held_code",  32'(key_code),  32'h9);
        chk("held_num",   32'(num),       32'h0009);
        chk("held_ready", 32'(key_ready), 32'h1);
        keys = 16'd0;
        repeat (3 * SWEEP - 1) @(negedge clk);
        chk("release_down_before", 32'(key_down), 32'h1);
        @(negedge clk);
        chk("release_down_after",  32'(key_down), 32'h0);

        // 3: digit entry 1,2,3,4 then 5
        press(4'h1, 4, 4);
        press(4'h2, 4, 4);
        press(4'h3, 4, 4);
        press(4'h4, 4, 4);
        chk("num_1234", 32'(num), 32'h1234);
        press(4'h5, 4, 4);
        chk("num_2345",  32'(num),      32'h2345);
        chk("code_5",    32'(key_code), 32'h5);

        // 4: bouncing key 6, then two keys at once
        for (int i = 0; i < 4; i++) begin
            keys = 16'd1 << 6;
            run_sweeps(1);
            keys = 16'd0;
            run_sweeps(1);
        end
        chk("bounce_down", 32'(key_down), 32'h0);
        keys = (16'd1 << 0) | (16'd1 << 5);
        run_sweeps(5);
        chk("multi_down", 32'(key_down), 32'h0);
        keys = 16'd0;
        run_sweeps(1);
        chk("multi_code", 32'(key_code), 32'h5);
        chk("multi_num",  32'(num),      32'h2345);

        // 5: ack behaviour, then ack + clear coinciding with an accept
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
        chk("ack_clears", 32'(key_ready), 32'h0);
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
        chk("ack_idle", 32'(key_ready), 32'h0);
        repeat (SWEEP - 2) @(negedge clk);
        push_exp(4'hA, 1'b1);
        keys = 16'd1 << 10;
        repeat (3 * SWEEP - 1) @(negedge clk);
        key_ack = 1'b1;
        num_clr = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
        num_clr = 1'b0;
        chk("coinc_ready", 32'(key_ready), 32'h1);
        chk("coinc_num",   32'(num),       32'h0);
        chk("coinc_code",  32'(key_code),  32'hA);
        repeat (SWEEP) @(negedge clk);
        keys = 16'd0;
        run_sweeps(4);
        chk("ready_kept", 32'(key_ready), 32'h1);
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
        chk("late_ack", 32'(key_ready), 32'h0);
        repeat (SWEEP - 1) @(negedge clk);

        // 6: reset in the middle of debouncing key 3
        keys = 16'd1 << 3;
        run_sweeps(2);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_values("midreset");
        rst = 1'b0;
        model_num = 16'd0;
        push_exp(4'h3, 1'b0);
        run_sweeps(4);
        keys = 16'd0;
        run_sweeps(4);
        chk("final_down", 32'(key_down), 32'h0);
        chk("final_num",  32'(num),      32'h0003);

        chk("pending_accepts", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
